// File: rtl/ptp_ts_pkg.sv
// ptp_ts_pkg: shared constants and types for RX PTP timestamp capture.
// Holds frame offsets, record layout and the parser state type.
package ptp_ts_pkg;

  localparam logic [15:0] ETHERTYPE_PTP = 16'h88F7;

  localparam logic [5:0] OFF_ETYPE    = 6'd12;
  localparam logic [5:0] OFF_ETYPE_LO = 6'd13;
  localparam logic [5:0] OFF_MSGTYPE  = 6'd14;
  localparam logic [5:0] OFF_SEQID    = 6'd44;
  localparam logic [5:0] OFF_SEQID_LO = 6'd45;
  localparam logic [5:0] IDX_MAX      = 6'd63;

  localparam int TS_SEC_LSB = 48;
  localparam int TS_NS_LSB  = 16;

  localparam int REC_SEC_LSB = 64;
  localparam int REC_NS_LSB  = 32;
  localparam int REC_SEQ_LSB = 16;
  localparam int REC_MSG_LSB = 12;
  localparam int REC_CNT_LSB = 0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PARSE,
    ST_SKIP
  } state_t;

  function automatic logic [95:0] make_rec(
    input logic [31:0] sec,
    input logic [31:0] ns,
    input logic [15:0] seq,
    input logic [3:0]  msg,
    input logic [7:0]  cnt
  );
    logic [95:0] r;
    r = '0;
    r[REC_SEC_LSB +: 32] = sec;
    r[REC_NS_LSB +: 32]  = ns;
    r[REC_SEQ_LSB +: 16] = seq;
    r[REC_MSG_LSB +: 4]  = msg;
    r[REC_CNT_LSB +: 8]  = cnt;
    return r;
  endfunction

endpackage

// File: rtl/ptp_rx_ts_capture.sv
// ptp_rx_ts_capture: timestamps RX frames at SOF, parses PTP header
// fields and emits one 96-bit record per good PTP frame.
module ptp_rx_ts_capture
  import ptp_ts_pkg::*;
(
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        en_i,
  input  logic [7:0]  s_axis_tdata,
  input  logic        s_axis_tvalid,
  input  logic        s_axis_tlast,
  input  logic        s_axis_tuser,
  output logic        s_axis_tready,
  input  logic [95:0] ptp_ts_96_i,
  output logic [95:0] m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic [15:0] drop_cnt_o
);

  state_t      state;
  logic [5:0]  idx;
  logic [31:0] sof_sec;
  logic [31:0] sof_ns;
  logic [3:0]  msg_type;
  logic [15:0] seq_id;
  logic        seq_done;
  logic [7:0]  rec_cnt;

  logic        beat;
  logic        eop;
  logic        seq_lo_beat;
  logic        etype_bad;
  logic        push;
  logic [7:0]  seq_lo;
  logic [95:0] rec;
  logic        unused_ts;

  assign s_axis_tready = 1'b1;
  assign unused_ts =
    ^{ptp_ts_96_i[95:80], ptp_ts_96_i[15:0]};

  assign beat = s_axis_tvalid;
  assign eop  = beat & s_axis_tlast;

  assign seq_lo_beat =
    beat && (idx == OFF_SEQID_LO);

  assign etype_bad =
    ((idx == OFF_ETYPE) &&
     (s_axis_tdata != ETHERTYPE_PTP[15:8])) ||
    ((idx == OFF_ETYPE_LO) &&
     (s_axis_tdata != ETHERTYPE_PTP[7:0]));

  // Low seqId byte may arrive on the tlast beat itself.
  assign seq_lo =
    seq_lo_beat ? s_axis_tdata : seq_id[7:0];

  assign push =
    (state == ST_PARSE) && eop &&
    !s_axis_tuser && (seq_done || seq_lo_beat);

  assign rec = make_rec(
    sof_sec, sof_ns,
    {seq_id[15:8], seq_lo},
    msg_type, rec_cnt);

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      idx <= '0;
    end else if (beat) begin
      if (s_axis_tlast)
        idx <= '0;
      else if (idx != IDX_MAX)
        idx <= idx + 6'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state    <= ST_IDLE;
      sof_sec  <= '0;
      sof_ns   <= '0;
      msg_type <= '0;
      seq_id   <= '0;
      seq_done <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (beat && !s_axis_tlast) begin
            sof_sec  <= ptp_ts_96_i[TS_SEC_LSB +: 32];
            sof_ns   <= ptp_ts_96_i[TS_NS_LSB +: 32];
            seq_done <= 1'b0;
            state    <= en_i ? ST_PARSE : ST_SKIP;
          end
        end
        ST_PARSE: begin
          if (beat) begin
            if (s_axis_tlast)
              state <= ST_IDLE;
            else if (etype_bad)
              state <= ST_SKIP;
            if (idx == OFF_MSGTYPE)
              msg_type <= s_axis_tdata[3:0];
            if (idx == OFF_SEQID)
              seq_id[15:8] <= s_axis_tdata;
            if (seq_lo_beat) begin
              seq_id[7:0] <= s_axis_tdata;
              seq_done    <= 1'b1;
            end
          end
        end
        ST_SKIP: begin
          if (eop)
            state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Single output register: a stalled record wins over a new one.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
      drop_cnt_o    <= '0;
      rec_cnt       <= '0;
    end else if (push) begin
      if (m_axis_tvalid && !m_axis_tready) begin
        if (drop_cnt_o != 16'hFFFF)
          drop_cnt_o <= drop_cnt_o + 16'd1;
      end else begin
        m_axis_tdata  <= rec;
        m_axis_tvalid <= 1'b1;
        rec_cnt       <= rec_cnt + 8'd1;
      end
    end else if (m_axis_tready) begin
      m_axis_tvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ptp_rx_ts_capture.sv
// tb_ptp_rx_ts_capture: table vectors, directed corner cases and
// random frames checked against a frame-level reference model.
module tb_ptp_rx_ts_capture;

  logic        clk;
  logic        rstn;
  logic        en;
  logic [7:0]  sd;
  logic        sv;
  logic        sl;
  logic        su;
  logic        srdy;
  logic [95:0] ts;
  logic [95:0] md;
  logic        mv;
  logic        mr;
  logic [15:0] drop;

  ptp_rx_ts_capture dut (
    .clk_i         (clk),
    .rstn_i        (rstn),
    .en_i          (en),
    .s_axis_tdata  (sd),
    .s_axis_tvalid (sv),
    .s_axis_tlast  (sl),
    .s_axis_tuser  (su),
    .s_axis_tready (srdy),
    .ptp_ts_96_i   (ts),
    .m_axis_tdata  (md),
    .m_axis_tvalid (mv),
    .m_axis_tready (mr),
    .drop_cnt_o    (drop)
  );

  int n_chk = 0;
  int n_fail = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name,
                     input logic [95:0] act,
                     input logic [95:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h",
               name, act, exp);
    end
  endtask

  // free-running or pinned PTP time
  logic        ts_load;
  logic [95:0] ts_val;
  always @(posedge clk)
    ts <= ts_load ? ts_val : ts + 96'h1_0000;

  logic rdy_rand;
  logic rdy_fix;
  always @(negedge clk)
    mr = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_fix;

  // reference model: one output slot, records judged per frame
  logic        mpush;
  logic [95:0] mrec;
  logic        m_v;
  logic [95:0] m_d;
  logic [15:0] m_drop;
  logic [7:0]  m_cnt;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_v    <= 1'b0;
      m_d    <= '0;
      m_drop <= '0;
      m_cnt  <= '0;
    end else if (mpush) begin
      if (m_v && !mr) begin
        if (m_drop != 16'hFFFF) m_drop <= m_drop + 16'd1;
      end else begin
        m_d   <= {mrec[95:8], m_cnt};
        m_v   <= 1'b1;
        m_cnt <= m_cnt + 8'd1;
      end
    end else if (m_v && mr) begin
      m_v <= 1'b0;
    end
  end

  logic chk_en;
  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_tvalid", {95'd0, mv}, {95'd0, m_v});
      chk("model_tdata", md, m_d);
      chk("model_drop", {80'd0, drop}, {80'd0, m_drop});
    end
  end

  byte unsigned fb[$];

  task automatic build(input int len, input logic [15:0] et,
                       input logic [3:0] mt,
                       input logic [15:0] seq);
    fb.delete();
    for (int i = 0; i < len; i++)
      fb.push_back(8'($urandom));
    if (len > 13) begin
      fb[12] = et[15:8];
      fb[13] = et[7:0];
    end
    if (len > 14) fb[14] = {4'($urandom), mt};
    if (len > 45) begin
      fb[44] = seq[15:8];
      fb[45] = seq[7:0];
    end
  endtask

  function automatic bit is_record(input bit enf,
                                   input bit tu, input int len);
    if (!enf || tu || len < 46) return 1'b0;
    return {fb[12], fb[13]} == 16'h88F7;
  endfunction

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      sv = 0; sl = 0; su = 0; mpush = 0;
      sd = 8'($urandom);
      en = 1'($urandom);
    end
  endtask

  task automatic send_frame(input int len, input bit enf,
                            input bit tu, input int maxgap,
                            input int stop);
    logic [95:0] ts0;
    ts0 = '0;
    for (int i = 0; i < stop; i++) begin
      if (i > 0) idle($urandom_range(0, maxgap));
      @(negedge clk);
      if (i == 0) ts0 = ts;
      sv = 1;
      sd = fb[i];
      en = (i == 0) ? enf : 1'($urandom);
      sl = (i == len - 1);
      su = (i == len - 1) ? tu : 1'($urandom);
      mpush = (i == len - 1) && is_record(enf, tu, len);
      if (len > 45)
        mrec = {ts0[79:48], ts0[47:16], fb[44], fb[45],
                fb[14][3:0], 4'h0, 8'h00};
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rstn = 0;
    sv = 0; sl = 0; su = 0; mpush = 0;
    #1;
    chk("rst_tvalid", {95'd0, mv}, 96'd0);
    chk("rst_tdata", md, 96'd0);
    chk("rst_drop", {80'd0, drop}, 96'd0);
    repeat (2) @(negedge clk);
    #2 rstn = 1;
  endtask

  typedef struct {
    bit          en;
    logic [15:0] et;
    logic [3:0]  mt;
    logic [15:0] seq;
    int          len;
    bit          tu;
    logic [31:0] sec;
    logic [31:0] ns;
    bit          ev;
    logic [95:0] ed;
  } vec_t;

  vec_t tbl[11];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int len;
    int r;
    logic [15:0] et;
    rstn = 0; en = 0; sd = 0; sv = 0; sl = 0; su = 0;
    ts_load = 1; ts_val = '0;
    rdy_rand = 0; rdy_fix = 1;
    chk_en = 0; mpush = 0; mrec = '0;
    #1;
    chk("rst_tvalid", {95'd0, mv}, 96'd0);
    chk("rst_tdata", md, 96'd0);
    chk("rst_drop", {80'd0, drop}, 96'd0);
    chk("s_tready", {95'd0, srdy}, 96'd1);
    repeat (3) @(negedge clk);
    #2 rstn = 1;
    chk_en = 1;

    // sync frame, pinned time
    ts_val = {48'd5, 32'd100, 16'h0};
    idle(2);
    build(60, 16'h88F7, 4'h0, 16'h1234);
    send_frame(60, 1, 0, 0, 60);
    idle(1);
    chk("sync_valid", {95'd0, mv}, 96'd1);
    chk("sync_data", md, 96'h00000005_00000064_1234_0_0_00);
    idle(1);
    chk("sync_release", {95'd0, mv}, 96'd0);

    tbl[0]  = '{1, 16'h88F7, 4'h0, 16'h0001, 40, 0,
                32'd1, 32'd1, 0, 96'h0};
    tbl[1]  = '{1, 16'h88F7, 4'h0, 16'h0002, 60, 0,
                32'd2, 32'd20, 1,
                96'h00000002_00000014_0002_0_0_00};
    tbl[2]  = '{1, 16'h0800, 4'h0, 16'h0003, 60, 0,
                32'd3, 32'd3, 0, 96'h0};
    tbl[3]  = '{1, 16'h88F7, 4'h0, 16'h0004, 60, 1,
                32'd4, 32'd4, 0, 96'h0};
    tbl[4]  = '{0, 16'h88F7, 4'h0, 16'h0005, 60, 0,
                32'd5, 32'd5, 0, 96'h0};
    tbl[5]  = '{1, 16'h8100, 4'h0, 16'h0006, 64, 0,
                32'd6, 32'd6, 0, 96'h0};
    tbl[6]  = '{1, 16'h88F7, 4'hB, 16'hABCD, 64, 0,
                32'd7, 32'h3B9AC9FF, 1,
                96'h00000007_3B9AC9FF_ABCD_B_0_01};
    tbl[7]  = '{1, 16'h88F7, 4'h8, 16'h55AA, 100, 0,
                32'h89ABCDEF, 32'h1, 1,
                96'h89ABCDEF_00000001_55AA_8_0_02};
    tbl[8]  = '{1, 16'h88F7, 4'h0, 16'h0009, 45, 0,
                32'd9, 32'd9, 0, 96'h0};
    tbl[9]  = '{1, 16'h88F7, 4'h0, 16'h000A, 1, 0,
                32'd10, 32'd10, 0, 96'h0};
    tbl[10] = '{1, 16'h88F7, 4'h1, 16'hFFFF, 47, 0,
                32'd0, 32'd0, 1,
                96'h00000000_00000000_FFFF_1_0_03};

    do_reset();
    for (int i = 0; i < 11; i++) begin
      ts_val = {16'h0, tbl[i].sec, tbl[i].ns, 16'hBEEF};
      idle(2);
      build(tbl[i].len, tbl[i].et, tbl[i].mt, tbl[i].seq);
      send_frame(tbl[i].len, tbl[i].en, tbl[i].tu, 2,
                 tbl[i].len);
      idle(1);
      chk($sformatf("tbl%0d_valid", i), {95'd0, mv},
          {95'd0, tbl[i].ev});
      if (tbl[i].ev)
        chk($sformatf("tbl%0d_data", i), md, tbl[i].ed);
      idle(2);
    end

    // backpressure: hold first record, drop second
    do_reset();
    rdy_fix = 0;
    ts_val = {48'd3, 32'd300, 16'h0};
    idle(2);
    build(60, 16'h88F7, 4'h2, 16'h1111);
    send_frame(60, 1, 0, 0, 60);
    build(60, 16'h88F7, 4'h3, 16'h2222);
    send_frame(60, 1, 0, 0, 60);
    idle(1);
    chk("bp_valid", {95'd0, mv}, 96'd1);
    chk("bp_data", md, 96'h00000003_0000012C_1111_2_0_00);
    chk("bp_drop", {80'd0, drop}, 96'd1);
    idle(3);
    chk("bp_held", md, 96'h00000003_0000012C_1111_2_0_00);
    rdy_fix = 1;
    idle(3);
    chk("bp_drain", {95'd0, mv}, 96'd0);

    // record counter wrap
    do_reset();
    ts_load = 0;
    for (int i = 0; i < 257; i++) begin
      build(47, 16'h88F7, 4'(i), 16'(i));
      send_frame(47, 1, 0, 0, 47);
      idle(1);
      if (i == 0 || i >= 254) begin
        chk($sformatf("wrap%0d_valid", i), {95'd0, mv}, 96'd1);
        chk($sformatf("wrap%0d_cnt", i), {88'd0, md[7:0]},
            {88'd0, 8'(i)});
      end
    end

    // reset in the middle of a PTP frame
    do_reset();
    ts_load = 1;
    rdy_fix = 0;
    idle(2);
    build(60, 16'h88F7, 4'h0, 16'h3333);
    send_frame(60, 1, 0, 0, 60);
    build(60, 16'h88F7, 4'h0, 16'h4444);
    send_frame(60, 1, 0, 0, 60);
    idle(1);
    chk("mid_pre_valid", {95'd0, mv}, 96'd1);
    chk("mid_pre_drop", {80'd0, drop}, 96'd1);
    build(60, 16'h88F7, 4'h0, 16'h5555);
    send_frame(60, 1, 0, 0, 20);
    @(negedge clk);
    sv = 1; sd = fb[20]; sl = 0; mpush = 0;
    #2 rstn = 0;
    #1;
    chk("mid_rst_valid", {95'd0, mv}, 96'd0);
    chk("mid_rst_data", md, 96'd0);
    chk("mid_rst_drop", {80'd0, drop}, 96'd0);
    @(negedge clk);
    sv = 0;
    @(negedge clk);
    #2 rstn = 1;
    rdy_fix = 1;
    idle(5);
    chk("mid_post_valid", {95'd0, mv}, 96'd0);

    // random frames with random backpressure
    do_reset();
    ts_load = 0;
    rdy_rand = 1;
    for (int k = 0; k < 80; k++) begin
      r = $urandom_range(0, 9);
      if (r < 1) len = 1;
      else if (r < 2) len = $urandom_range(2, 45);
      else len = $urandom_range(47, 90);
      r = $urandom_range(0, 9);
      et = (r < 6) ? 16'h88F7 : (r < 8) ? 16'h0800 : 16'h8100;
      build(len, et, 4'($urandom), 16'($urandom));
      send_frame(len, ($urandom_range(0, 4) != 0),
                 ($urandom_range(0, 5) == 0), 2, len);
      idle($urandom_range(0, 3));
    end
    rdy_rand = 0;
    rdy_fix = 1;
    idle(5);
    chk("rand_drain", {95'd0, mv}, 96'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ptp_rx_ts_capture.md
PTP_RX_TS_CAPTURE -- requirements
Module: ptp_rx_ts_capture

Interface
REQ-001 SHALL provide: clk_i  in  1  single clock (Ethernet RX clock domain); all logic rising-edge.
REQ-002 SHALL provide: rstn_i  in  1  asynchronous reset, active-low.
REQ-003 SHALL provide: en_i  in  1  capture enable, sampled at start of frame only.
REQ-004 SHALL provide: s_axis_tdata  in  8  MAC RX byte stream (monitor tap).
REQ-005 SHALL provide: s_axis_tvalid / s_axis_tlast / s_axis_tuser  in  1 each  byte valid, last byte, frame error (meaningful with tlast).
REQ-006 SHALL provide: s_axis_tready  out  1  tied 1; block never stalls the MAC.
REQ-007 SHALL provide: ptp_ts_96_i  in  96  free-running PTP time {sec[47:0], ns[31:0], fns[15:0]}.
REQ-008 SHALL provide: m_axis_tdata  out  96  timestamp record to the 96->32 CDC/width-conversion stage.
REQ-009 SHALL provide: m_axis_tvalid  out  1 / m_axis_tready  in  1  AXIS handshake.
REQ-010 SHALL provide: drop_cnt_o  out  16  saturating count of records lost to output backpressure.

Function
REQ-011 Record format SHALL be [95:64] sec[31:0], [63:32] ns, [31:16] PTP sequenceId, [15:12] messageType, [11:8] 0, [7:0] record counter.
REQ-012 Timestamp SHALL be latched from ptp_ts_96_i on the first valid byte of each frame (byte 0).
REQ-013 Byte index counter SHALL be 6 bits, increment per valid byte, saturate at 63, clear on tlast.
REQ-014 FSM states: IDLE, PARSE, SKIP; reset state IDLE.
REQ-015 IDLE: valid byte with en_i=1 -> PARSE (byte 0 consumed); with en_i=0 -> SKIP; a single-byte frame (tvalid&tlast in IDLE) stays IDLE, no record.
REQ-016 PARSE: bytes 12,13 SHALL equal 16'h88F7, else -> SKIP; byte 14[3:0] -> messageType; bytes 44,45 -> sequenceId (big-endian).
REQ-017 PARSE on tlast: push record iff tuser=0 and byte 45 already received; otherwise discard; -> IDLE.
REQ-018 SKIP: ignore bytes until tlast -> IDLE; VLAN-tagged (0x8100) frames SHALL be skipped.
REQ-019 en_i deasserted mid-frame SHALL NOT abort the frame being parsed.
REQ-020 Push SHALL assert m_axis_tvalid the cycle after the tlast beat; data stable while tvalid=1 and tready=0.
REQ-021 Output is one register: push while tvalid=1 and tready=0 SHALL discard the new record and increment drop_cnt_o (saturate at 16'hFFFF).
REQ-022 Push in the same cycle as tready=1 handshake SHALL replace the record without drop.
REQ-023 Record counter (8 bit) SHALL increment per pushed record, wrap 8'hFF -> 8'h00; dropped records do not increment it.
REQ-024 tvalid gaps (tvalid=0) inside a frame SHALL not advance the byte index.

Reset
REQ-025 On rstn_i low: FSM IDLE, m_axis_tvalid=0, m_axis_tdata=0, drop_cnt_o=0, record counter=0, byte index=0, asynchronously.
REQ-026 Reset mid-frame SHALL discard the frame; remaining bytes after release until tlast are treated as a new frame start (no guarantee beyond being skipped or yielding no valid PTP record).

Structure
REQ-027 Package ptp_ts_pkg SHALL hold ETHERTYPE_PTP, byte offsets (12, 14, 44), record field positions, and the FSM state typedef.
REQ-028 No sub-module; single flat module.

Verification
REQ-029 Sync frame, ethertype 88F7, msgType 0, seqId 16'h1234, ts sec=5 ns=100 at byte 0, tready=1 -> one record 96'h00000005_00000064_1234_0_0_00 the cycle after tlast.
REQ-030 Non-PTP frame (ethertype 0800) and PTP frame with tuser=1 on tlast -> no m_axis_tvalid.
REQ-031 tready=0, two PTP frames back-to-back -> first record held stable, second dropped, drop_cnt_o=1, counter field of held record 8'h00.
REQ-032 PTP frame truncated at 40 bytes -> no record; next valid PTP frame -> record counter field 8'h00.
REQ-033 256 accepted PTP frames -> counter field 8'hFF then wraps to 8'h00 on the 257th.
REQ-034 rstn_i asserted at byte 20 of a PTP frame -> all outputs 0 immediately; no record emitted for that frame.
